mc_main_ctrl: RTL and testbench

Multicycle MIPS main control FSM: the producer side of the `alu_op` interface. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath muxes and write strobes, and it drives `alu_op` to the ALU control decoder. Memory accesses use a ready handshake so that instruction and data memory can share the UART-side bus and stall.

---
 rtl/mc_main_ctrl.sv | 155 +++++++++++++++
 tb/tb_mc_main_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and produces Moore datapath controls plus alu_op for the ALU control decoder.
module mc_main_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t r_state;
  state_t w_next;
  logic   w_pc_write;
  logic   w_branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = FETCH;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    w_pc_write = 1'b0;
    w_branch   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        // Strobes are gated by rst_n so nothing is written while reset is held.
        ir_write   = mem_ready & rst_n;
        w_pc_write = mem_ready & rst_n;
        w_next     = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXEC;
          OP_BEQ:       w_next = BRANCH;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JUMP;
          default: begin
            w_next     = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      w_next = MEMRD;
        else if (opcode == OP_SW) w_next = MEMWR;
        else                      w_next = FETCH;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        w_next   = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        w_next    = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        w_branch  = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
      end
      JUMP: begin
        pc_src     = 2'b10;
        w_pc_write = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

  assign pc_write = w_pc_write;
  assign branch   = w_branch;
  assign pc_en    = w_pc_write | (w_branch & zero);
  assign state    = r_state;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: walks each instruction class, stalls, illegal
// opcode and mid-instruction reset, checking Moore outputs against hand values.
module tb_mc_main_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write, branch, pc_en;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;
  logic watch_rw = 1'b0;
  logic rw_seen  = 1'b0;

  mc_main_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .pc_en(pc_en), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  always @(reg_write or posedge clk)
    if (watch_rw && reg_write === 1'b1) rw_seen = 1'b1;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00; zero = 1'b0;
    #3;
    chk("rst_state", state, 4'd0);
    chk("rst_pc_en", pc_en, 1'b0);
    chk("rst_ir_write", ir_write, 1'b0);
    chk("rst_pc_write", pc_write, 1'b0);
    chk("rst_mem_read", mem_read, 1'b1);
    chk("rst_alu_src_b", alu_src_b, 2'b01);
    tick();
    chk("rst_hold_state", state, 4'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_state", state, 4'd0);
    chk("rel_ir_write", ir_write, 1'b1);
    chk("rel_pc_en", pc_en, 1'b1);

    // lw
    opcode = 6'h23;
    tick(); chk("lw_s1", state, 4'd1); chk("lw_s1_srcb", alu_src_b, 2'b11);
    chk("lw_s1_aluop", alu_op, 2'b00);
    tick(); chk("lw_s2", state, 4'd2); chk("lw_s2_srca", alu_src_a, 1'b1);
    chk("lw_s2_srcb", alu_src_b, 2'b10); chk("lw_s2_rw", reg_write, 1'b0);
    tick(); chk("lw_s3", state, 4'd3); chk("lw_s3_iord", iord, 1'b1);
    chk("lw_s3_mrd", mem_read, 1'b1); chk("lw_s3_rw", reg_write, 1'b0);
    chk("lw_s3_m2r", mem_to_reg, 1'b0);
    tick(); chk("lw_s4", state, 4'd4); chk("lw_s4_rw", reg_write, 1'b1);
    chk("lw_s4_m2r", mem_to_reg, 1'b1); chk("lw_s4_rdst", reg_dst, 1'b0);
    chk("lw_s4_aluop", alu_op, 2'b00);
    tick(); chk("lw_s0", state, 4'd0);

    // R-type
    opcode = 6'h00;
    tick(); chk("r_s1", state, 4'd1);
    tick(); chk("r_s6", state, 4'd6); chk("r_s6_aluop", alu_op, 2'b10);
    chk("r_s6_srcb", alu_src_b, 2'b00); chk("r_s6_srca", alu_src_a, 1'b1);
    tick(); chk("r_s7", state, 4'd7); chk("r_s7_rdst", reg_dst, 1'b1);
    chk("r_s7_rw", reg_write, 1'b1); chk("r_s7_m2r", mem_to_reg, 1'b0);
    tick(); chk("r_s0", state, 4'd0);

    // beq taken and not taken
    opcode = 6'h04;
    tick(); tick(); zero = 1'b1; #1;
    chk("beq1_s8", state, 4'd8); chk("beq1_pc_en", pc_en, 1'b1);
    chk("beq1_pc_src", pc_src, 2'b01); chk("beq1_aluop", alu_op, 2'b01);
    chk("beq1_pc_write", pc_write, 1'b0);
    tick(); chk("beq1_s0", state, 4'd0);
    zero = 1'b0;
    tick(); tick(); chk("beq0_s8", state, 4'd8); chk("beq0_pc_en", pc_en, 1'b0);
    chk("beq0_aluop", alu_op, 2'b01); chk("beq0_branch", branch, 1'b1);
    tick(); chk("beq0_s0", state, 4'd0);

    // addi
    opcode = 6'h08;
    tick(); tick(); chk("addi_s9", state, 4'd9); chk("addi_s9_srcb", alu_src_b, 2'b10);
    tick(); chk("addi_s10", state, 4'd10); chk("addi_s10_rw", reg_write, 1'b1);
    chk("addi_s10_rdst", reg_dst, 1'b0);
    tick(); chk("addi_s0", state, 4'd0);

    // j
    opcode = 6'h02;
    tick(); tick(); chk("j_s11", state, 4'd11); chk("j_pc_src", pc_src, 2'b10);
    chk("j_pc_en", pc_en, 1'b1);
    tick(); chk("j_s0", state, 4'd0);

    // sw with three wait cycles in MEMWR
    opcode = 6'h2B;
    tick(); tick(); chk("sw_s2", state, 4'd2);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("sw_wait_state", state, 4'd5);
      chk("sw_wait_mwr", mem_write, 1'b1);
      chk("sw_wait_iord", iord, 1'b1);
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("sw_done_state", state, 4'd5); chk("sw_done_mwr", mem_write, 1'b1);
    chk("sw_done_iord", iord, 1'b1);
    tick(); chk("sw_s0", state, 4'd0); chk("sw_s0_mwr", mem_write, 1'b0);

    // FETCH stall of two cycles, then an illegal opcode
    mem_ready = 1'b0; opcode = 6'h3F; #1;
    chk("fst_irw0", ir_write, 1'b0); chk("fst_mrd", mem_read, 1'b1);
    tick(); chk("fst_state1", state, 4'd0); chk("fst_irw1", ir_write, 1'b0);
    tick(); chk("fst_state2", state, 4'd0);
    mem_ready = 1'b1; #1; chk("fst_irw_go", ir_write, 1'b1);
    tick(); chk("ill_s1", state, 4'd1); chk("ill_pulse", illegal_op, 1'b1);
    tick(); chk("ill_s0", state, 4'd0); chk("ill_clear", illegal_op, 1'b0);

    // reset during MEMRD
    opcode = 6'h23;
    tick(); tick(); mem_ready = 1'b0;
    tick(); chk("rmr_s3", state, 4'd3);
    watch_rw = 1'b1;
    tick(); #1; rst_n = 1'b0; #1;
    chk("rmr_async_state", state, 4'd0); chk("rmr_rw", reg_write, 1'b0);
    mem_ready = 1'b1; #1;
    chk("rmr_irw", ir_write, 1'b0); chk("rmr_pc_en", pc_en, 1'b0);
    tick(); chk("rmr_hold", state, 4'd0);
    @(negedge clk); mem_ready = 1'b0; rst_n = 1'b1; #1;
    chk("rmr_rel_state", state, 4'd0);
    tick(); tick();
    chk("rmr_after", state, 4'd0);
    watch_rw = 1'b0;
    chk("rmr_no_rw", rw_seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
